// File: rtl/outnet_pkg.sv
// Shared definitions for the XOR window output network: FSM states, width helper
// and the window-legality rule that the readout controller also applies.
package outnet_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic win_legal(input int w, input int xmax);
        return (w > 0) && (w <= xmax);
    endfunction

endpackage

// File: rtl/xor_win_lane.sv
// One output bit of the XOR window network: parity of the i_win chains starting at
// chain BASE, wrapping cyclically over the K chains.
module xor_win_lane #(
    parameter int K    = 10,
    parameter int XMAX = K,
    parameter int BASE = 0
) (
    input  logic [K-1:0]                 i_v,
    input  logic [$clog2(XMAX+1)-1:0]    i_win,
    output logic                         o_bit
);

    logic [K-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int j = 0; j < K; j++) begin
            if (j < int'(i_win)) begin
                w_mask[(BASE + j) % K] = 1'b1;
            end
        end
    end

    assign o_bit = ^(i_v & w_mask);

endmodule

// File: rtl/xor_window_net.sv
// Registered, handshaked XOR window network combining K arbiter chains into M PUF bits.
// Define OUTNET_TMV_EN to build temporal majority voting over R samples per response.
module xor_window_net
    import outnet_pkg::*;
#(
    parameter int K    = 10,
    parameter int M    = K - 1,
    parameter int XMAX = K,
    parameter int S    = 0,
    parameter int R    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(XMAX+1)-1:0]    cfg_win,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [K-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M-1:0]                 out_data,
    output logic                         out_err,
    output logic                         busy
);

    localparam int WW = cnt_bits(XMAX);

    if ((R < 3) || ((R % 2) == 0)) begin : g_bad_r
        $error("xor_window_net: R must be odd and at least 3");
    end

    logic          w_accept;
    logic          w_load;
    logic [K-1:0]  w_vote;
    logic [WW-1:0] w_win;
    logic [M-1:0]  w_lanes;
    logic          w_err;

    logic          r_out_valid;
    logic [M-1:0]  r_out_data;
    logic          r_out_err;

    // Handshake: a sample is taken on in_valid && in_ready; a response is consumed on
    // out_valid && out_ready. Input stalls only while a response waits unconsumed.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

`ifdef OUTNET_TMV_EN
    localparam int CW = cnt_bits(R);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_last;
    logic [CW-1:0] r_cnt [K];
    logic [CW-1:0] r_smp;
    logic [WW-1:0] r_win;

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_state_next = ACC;
            ACC: begin
                if (w_accept && (r_smp == CW'(R - 1))) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The vote includes the sample being accepted on the final cycle of the group.
    always_comb begin
        w_vote = '0;
        for (int j = 0; j < K; j++) begin
            w_vote[j] = (r_cnt[j] + CW'(in_data[j])) > CW'(R / 2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_smp   <= '0;
            r_win   <= '0;
            for (int j = 0; j < K; j++) r_cnt[j] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (r_state == IDLE) r_win <= cfg_win;
                if (w_last) begin
                    r_smp <= '0;
                    for (int j = 0; j < K; j++) r_cnt[j] <= '0;
                end else begin
                    r_smp <= r_smp + 1'b1;
                    for (int j = 0; j < K; j++) r_cnt[j] <= r_cnt[j] + CW'(in_data[j]);
                end
            end
        end
    end

    assign w_win  = r_win;
    assign w_load = w_last;
    assign busy   = (r_state != IDLE) || r_out_valid;
`else
    assign w_vote = in_data;
    assign w_win  = cfg_win;
    assign w_load = w_accept;
    assign busy   = r_out_valid;
`endif

    for (genvar i = 0; i < M; i++) begin : g_lane
        xor_win_lane #(
            .K    (K),
            .XMAX (XMAX),
            .BASE ((i + S) % K)
        ) u_lane (
            .i_v   (w_vote),
            .i_win (w_win),
            .o_bit (w_lanes[i])
        );
    end

    assign w_err = !win_legal(int'(w_win), XMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_err   <= w_err;
            r_out_data  <= w_err ? '0 : w_lanes;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_xor_window_net.sv
// Directed bench for xor_window_net (K=10, M=9, S=0, XMAX=10, R=3); a group is one
// sample by default or three with OUTNET_TMV_EN.
module tb_xor_window_net;

`ifdef OUTNET_TMV_EN
    localparam int GRP = 3;
`else
    localparam int GRP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cfg_win = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_data;
    logic       out_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];  // {err, data}

    xor_window_net #(.K(10), .M(9), .XMAX(10), .S(0), .R(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_win   (cfg_win),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every consumed response must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [9:0] exp_v;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got err=%b data=%h required none", out_err, out_data);
            end else begin
                exp_v = exp_q.pop_front();
                if ({out_err, out_data} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_response got err=%b data=%h required err=%b data=%h",
                             out_err, out_data, exp_v[9], exp_v[8:0]);
                end
            end
        end
    end

    task automatic send_sample(input logic [3:0] w, input logic [9:0] d);
        int waited = 0;
        cfg_win  = w;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [3:0] w, input logic [9:0] d);
        for (int k = 0; k < GRP; k++) send_sample(w, d);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_valid); end
        if (out_data !== 9'h000) begin errors++; $display("FAIL reset_data got %h required 000", out_data); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", out_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_function;
        logic [3:0]  w_t [3] = '{4'd9, 4'd1, 4'd10};
        logic [9:0]  d_t [3] = '{10'h001, 10'h2AA, 10'h001};
        logic [8:0]  e_t [3] = '{9'h1FD, 9'h0AA, 9'h1FF};
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back({1'b0, e_t[t]});
            send_group(w_t[t], d_t[t]);
            @(negedge clk);
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL func_valid[%0d] got %b required 1", t, out_valid); end
            if (out_data !== e_t[t]) begin errors++; $display("FAIL func_data[%0d] got %h required %h", t, out_data, e_t[t]); end
            if (out_err !== 1'b0) begin errors++; $display("FAIL func_err[%0d] got %b required 0", t, out_err); end
            if (busy !== 1'b1) begin errors++; $display("FAIL func_busy[%0d] got %b required 1", t, busy); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL func_drain_valid got %b required 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL func_drain_busy got %b required 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 9'h1FF});
        exp_q.push_back({1'b0, 9'h002});
        exp_q.push_back({1'b0, 9'h180});
        send_group(4'd5, 10'h3FF);
        send_group(4'd2, 10'h003);
        send_group(4'd3, 10'h200);
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b required 1", out_valid); end
        if (out_data !== 9'h180) begin errors++; $display("FAIL b2b_wrap got %h required 180", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_win;
        logic [3:0] w_t [2] = '{4'd0, 4'd11};
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back({1'b1, 9'h000});
            send_group(w_t[t], 10'h3FF);
            @(negedge clk);
            checks += 2;
            if (out_err !== 1'b1) begin errors++; $display("FAIL illegal_err[W=%0d] got %b required 1", w_t[t], out_err); end
            if (out_data !== 9'h000) begin errors++; $display("FAIL illegal_data[W=%0d] got %h required 000", w_t[t], out_data); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 9'h055});
        exp_q.push_back({1'b0, 9'h0AA});
        send_group(4'd1, 10'h055);
        cfg_win  = 4'd1;
        in_data  = 10'h0AA;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b required 1", k, out_valid); end
            if (out_data !== 9'h055) begin errors++; $display("FAIL stall_hold[%0d] got %h required 055", k, out_data); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b required 0", k, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < GRP; k++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_second_valid got %b required 1", out_valid); end
        if (out_data !== 9'h0AA) begin errors++; $display("FAIL stall_second_data got %h required 0AA", out_data); end
        @(posedge clk); #1;
    endtask

`ifdef OUTNET_TMV_EN
    task automatic test_tmv_vote;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 9'h001});
        send_sample(4'd1, 10'h001);
        send_sample(4'd1, 10'h001);
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL tmv_early_valid got %b required 0", out_valid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL tmv_busy got %b required 1", busy); end
        // cfg_win changes mid-group must be ignored.
        send_sample(4'd10, 10'h000);
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL tmv_valid got %b required 1", out_valid); end
        if (out_data !== 9'h001) begin errors++; $display("FAIL tmv_data got %h required 001", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_tmv_reset;
        out_ready = 1'b1;
        send_sample(4'd1, 10'h3FF);
        send_sample(4'd1, 10'h3FF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL tmvrst_valid got %b required 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL tmvrst_busy got %b required 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL tmvrst_in_ready got %b required 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 9'h000});
        send_sample(4'd1, 10'h000);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL tmvrst_partial got %b required 0", out_valid); end
        send_sample(4'd1, 10'h000);
        send_sample(4'd1, 10'h000);
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL tmvrst_group_valid got %b required 1", out_valid); end
        if (out_data !== 9'h000) begin errors++; $display("FAIL tmvrst_group_data got %h required 000", out_data); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_function();
        test_back_to_back();
        test_illegal_win();
        test_stall();
`ifdef OUTNET_TMV_EN
        test_tmv_vote();
        test_tmv_reset();
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
